// File: rtl/sram_controller.sv
// 32-bit CPU load/store port onto a 16-bit SRAM: every word is moved as a low then a high halfword.
// Build option SRAM_CTRL_ERR_EN adds an err output that rejects misaligned or below-base addresses.
module sram_controller #(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
`ifdef SRAM_CTRL_ERR_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(WAIT_STATES);

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_cnt;
    logic [2:0]  w_next_cnt;
    logic [31:0] r_read_data;

    logic        w_req;
    logic        w_last;
    logic        w_xfer;
    logic        w_high;
    logic        w_write;
    logic        w_read;
    logic [31:0] w_offset;
    logic        w_unused;
    logic        w_bad;

    assign w_req    = wr_en | rd_en;
    assign w_last   = (r_cnt == LAST_CNT);
    assign w_xfer   = (r_state == LOW) || (r_state == HIGH);
    assign w_high   = (r_state == HIGH);
    // A simultaneous write and read request is served as a write only.
    assign w_write  = w_xfer & wr_en;
    assign w_read   = rd_en & ~wr_en;
    assign w_offset = address - ADDR_BASE;
    assign w_unused = ^{w_offset[31:19], w_offset[1:0]};

`ifdef SRAM_CTRL_ERR_EN
    assign w_bad = (address[1:0] != 2'b00) || (address < ADDR_BASE);
`else
    assign w_bad = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_read_data <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_read && w_last && (r_state == LOW))
                r_read_data[15:0] <= sram_dq_in;
            if (w_read && w_last && (r_state == HIGH))
                r_read_data[31:16] <= sram_dq_in;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next_cnt   = '0;
                    w_next_state = w_bad ? DONE : LOW;
                end
            end
            LOW: begin
                if (w_last) begin
                    w_next_state = HIGH;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 3'd1;
                end
            end
            HIGH: begin
                if (w_last) begin
                    w_next_state = DONE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 3'd1;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

`ifdef SRAM_CTRL_ERR_EN
    logic r_bad;

    // Remembers, across the single DONE cycle, whether the accepted request was rejected.
    always_ff @(posedge clk) begin
        if (rst)
            r_bad <= 1'b0;
        else if (r_state == IDLE)
            r_bad <= w_req & w_bad;
    end

    assign err = r_bad && (r_state == DONE);
`endif

    assign ready       = ~w_req | (r_state == DONE);
    assign read_data   = r_read_data;
    assign sram_addr   = w_xfer ? {w_offset[18:2], w_high} : 18'd0;
    assign sram_we_n   = ~w_write;
    assign sram_dq_oe  = w_write;
    assign sram_dq_out = w_write ? (w_high ? write_data[31:16] : write_data[15:0]) : 16'd0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed scenarios with literal expectations plus random traffic
// checked every cycle against a transaction-level model. Define SRAM_CTRL_ERR_EN to cover err too.
module tb_sram_controller;

    localparam int          W       = 1;
    localparam int          LAST_LO = W + 1;
    localparam int          LAST_HI = 2 * W + 2;
    localparam int          T_DONE  = 2 * W + 3;
    localparam logic [31:0] BASE    = 32'd1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    logic        wr_en0, rd_en0;
    logic [31:0] address0, write_data0, read_data0;
    logic        ready0;
    logic [17:0] sram_addr0;
    logic [15:0] sram_dq_out0, sram_dq_in0;
    logic        sram_dq_oe0, sram_we_n0;
`ifdef SRAM_CTRL_ERR_EN
    logic        err, err0;
`endif

    sram_controller #(.WAIT_STATES(W), .ADDR_BASE(BASE)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
`ifdef SRAM_CTRL_ERR_EN
        , .err(err)
`endif
    );

    sram_controller #(.WAIT_STATES(0), .ADDR_BASE(BASE)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en0), .rd_en(rd_en0), .address(address0),
        .write_data(write_data0), .read_data(read_data0), .ready(ready0),
        .sram_addr(sram_addr0), .sram_dq_out(sram_dq_out0), .sram_dq_oe(sram_dq_oe0),
        .sram_dq_in(sram_dq_in0), .sram_we_n(sram_we_n0)
`ifdef SRAM_CTRL_ERR_EN
        , .err(err0)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] hidx(input logic [31:0] a, input logic hi);
        return 10'((((a - BASE) >> 2) << 1) + (hi ? 32'd1 : 32'd0));
    endfunction

    // SRAM device seen by the W=1 instance; a reset edge aborts a pending strobe.
    logic [15:0] dev_mem [0:1023];
    logic        m_valid = 1'b0;
    assign sram_dq_in  = dev_mem[sram_addr[9:0]];
    assign sram_dq_in0 = 16'hA000 | {4'h0, sram_addr0[11:0]};

    always @(posedge clk) begin
        if (!m_valid) begin
            for (int i = 0; i < 1024; i++) dev_mem[i] <= 16'h0000;
        end else if (!rst && !sram_we_n) begin
            dev_mem[sram_addr[9:0]] <= sram_dq_out;
        end
    end

    // Reference: m_t is the cycle index within the current access (-1 when idle);
    // a half commits to memory (or into read data) at the end of its phase.
    logic [15:0] ref_mem [0:1023];
    int          m_t = -1;
    logic [31:0] m_rd;
    logic        m_err;

    always @(posedge clk) begin
        if (rst) begin
            if (!m_valid)
                for (int i = 0; i < 1024; i++) ref_mem[i] <= 16'h0000;
            m_t     <= -1;
            m_rd    <= 32'd0;
            m_err   <= 1'b0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            if (m_t < 0) begin
                if (wr_en || rd_en) begin
`ifdef SRAM_CTRL_ERR_EN
                    if (address[1:0] != 2'b00 || address < BASE) begin
                        m_t   <= T_DONE;
                        m_err <= 1'b1;
                    end else begin
                        m_t   <= 1;
                        m_err <= 1'b0;
                    end
`else
                    m_t <= 1;
`endif
                end
            end else begin
                if (m_t == LAST_LO) begin
                    if (wr_en) ref_mem[hidx(address, 1'b0)] <= write_data[15:0];
                    else if (rd_en) m_rd[15:0] <= ref_mem[hidx(address, 1'b0)];
                end
                if (m_t == LAST_HI) begin
                    if (wr_en) ref_mem[hidx(address, 1'b1)] <= write_data[31:16];
                    else if (rd_en) m_rd[31:16] <= ref_mem[hidx(address, 1'b1)];
                end
                m_t <= (m_t == T_DONE) ? -1 : m_t + 1;
            end
        end
    end

    logic        c_lo, c_hi, c_dn, c_wr;
    logic [17:0] c_addr;

    always @(negedge clk) begin
        if (m_valid) begin
            c_lo   = (m_t >= 1) && (m_t <= LAST_LO);
            c_hi   = (m_t > LAST_LO) && (m_t <= LAST_HI);
            c_dn   = (m_t == T_DONE);
            c_wr   = (c_lo || c_hi) && wr_en;
            c_addr = (c_lo || c_hi) ? 18'((((address - BASE) >> 2) << 1) + (c_hi ? 32'd1 : 32'd0)) : 18'd0;
            check("ready", 32'(ready), 32'(!(wr_en || rd_en) || c_dn));
            check("sram_addr", 32'(sram_addr), 32'(c_addr));
            check("sram_we_n", 32'(sram_we_n), 32'(!c_wr));
            check("sram_dq_oe", 32'(sram_dq_oe), 32'(c_wr));
            if (c_wr)
                check("sram_dq_out", 32'(sram_dq_out), 32'(c_hi ? write_data[31:16] : write_data[15:0]));
            check("read_data", read_data, m_rd);
`ifdef SRAM_CTRL_ERR_EN
            check("err", 32'(err), 32'(c_dn && m_err));
`endif
        end
    end

    // Issue one request right after a rising edge, hold it until ready, drop it after the edge.
    task automatic req(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                       output int freeze);
        wr_en = w; rd_en = r; address = a; write_data = d;
        freeze = 0;
        @(negedge clk);
        while (!ready && freeze < 40) begin
            freeze++;
            @(negedge clk);
        end
        if (freeze >= 40) check("ready_timeout", 32'(freeze), 32'(T_DONE));
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int fz;

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = BASE; write_data = 32'd0;
        wr_en0 = 1'b0; rd_en0 = 1'b0; address0 = BASE; write_data0 = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_read_data", read_data, 32'd0);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_out", 32'(sram_dq_out), 32'd0);
        @(posedge clk); #1;

        // Write 0xDEADBEEF to 1024: halfword 0 then 1, two cycles each, five freeze cycles.
        wr_en = 1'b1; address = 32'd1024; write_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("w_c0_ready", 32'(ready), 32'd0);
        check("w_c0_we_n", 32'(sram_we_n), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("w_ready", 32'(ready), 32'd0);
            check("w_addr", 32'(sram_addr), (k <= 2) ? 32'd0 : 32'd1);
            check("w_dq_out", 32'(sram_dq_out), (k <= 2) ? 32'h0000_BEEF : 32'h0000_DEAD);
            check("w_we_n", 32'(sram_we_n), 32'd0);
        end
        @(negedge clk);
        check("w_c5_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        wr_en = 1'b0;

        req(1'b0, 1'b1, 32'd1024, 32'd0, fz);
        check("r1024_freeze", 32'(fz), 32'd5);
        check("r1024_data", read_data, 32'hDEAD_BEEF);

        // Back-to-back write then read of 1028 with no idle gap between requests.
        req(1'b1, 1'b0, 32'd1028, 32'hCAFE_F00D, fz);
        check("b2b_w_freeze", 32'(fz), 32'd5);
        req(1'b0, 1'b1, 32'd1028, 32'd0, fz);
        check("b2b_r_freeze", 32'(fz), 32'd5);
        check("b2b_r_data", read_data, 32'hCAFE_F00D);

`ifdef SRAM_CTRL_ERR_EN
        rd_en = 1'b1; address = 32'd1026;
        @(negedge clk);
        check("err_c0_ready", 32'(ready), 32'd0);
        check("err_c0_err", 32'(err), 32'd0);
        @(negedge clk);
        check("err_c1_ready", 32'(ready), 32'd1);
        check("err_c1_err", 32'(err), 32'd1);
        check("err_c1_we_n", 32'(sram_we_n), 32'd1);
        check("err_c1_data", read_data, 32'hCAFE_F00D);
        @(posedge clk); #1;
        rd_en = 1'b0;
`endif

        // Reset during the first HIGH cycle of a write to 1032: only the low half lands.
        wr_en = 1'b1; address = 32'd1032; write_data = 32'h1111_2222;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rstw_high_addr", 32'(sram_addr), 32'd5);
        check("rstw_high_we_n", 32'(sram_we_n), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check("rstw_we_n", 32'(sram_we_n), 32'd1);
        check("rstw_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rstw_addr", 32'(sram_addr), 32'd0);
        check("rstw_read_data", read_data, 32'd0);
        @(posedge clk); #1;
        req(1'b0, 1'b1, 32'd1032, 32'd0, fz);
        check("rstw_readback", read_data, 32'h0000_2222);

        // Zero wait states: read 1032 touches halfwords 4 and 5, three freeze cycles.
        rd_en0 = 1'b1; address0 = 32'd1032;
        @(negedge clk);
        check("w0_c0_ready", 32'(ready0), 32'd0);
        check("w0_c0_addr", 32'(sram_addr0), 32'd0);
        @(negedge clk);
        check("w0_c1_ready", 32'(ready0), 32'd0);
        check("w0_c1_addr", 32'(sram_addr0), 32'd4);
        check("w0_c1_we_n", 32'(sram_we_n0), 32'd1);
        @(negedge clk);
        check("w0_c2_ready", 32'(ready0), 32'd0);
        check("w0_c2_addr", 32'(sram_addr0), 32'd5);
        check("w0_c2_dq_oe", 32'(sram_dq_oe0), 32'd0);
        @(negedge clk);
        check("w0_c3_ready", 32'(ready0), 32'd1);
        check("w0_c3_data", read_data0, 32'hA005_A004);
        check("w0_c3_dq_out", 32'(sram_dq_out0), 32'd0);
`ifdef SRAM_CTRL_ERR_EN
        check("w0_c3_err", 32'(err0), 32'd0);
`endif
        @(posedge clk); #1;
        rd_en0 = 1'b0;

        // Random mix of writes, reads and combined requests over a small window of words.
        for (int n = 0; n < 200; n++) begin
            int op;
            int gap;
            op  = int'($urandom_range(0, 2));
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                @(posedge clk); #1;
            end
            req(op != 1, op != 0, BASE + 32'($urandom_range(0, 15)) * 32'd4, $urandom, fz);
            check("rand_freeze", 32'(fz), 32'd5);
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
